// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack crossing: takes a word on valid/ready, holds it on
// x_data while x_req is high, and completes once the synchronized ack has risen and fallen.
module cdc_handshake_tx #(
  parameter int WIDTH      = 8,
  parameter int SYNC_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             x_req,
  output logic [WIDTH-1:0] x_data,
  input  logic             x_ack,
  output logic             busy,
  output logic             done
);

  // state   | meaning
  // IDLE    | no transfer in flight; accepts once any stale ack has dropped
  // REQ     | x_req high, x_data held, waiting for the synchronized ack to rise
  // RELEASE | x_req low, waiting for the synchronized ack to fall
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t                state;
  logic [SYNC_DEPTH-1:0] ack_sync;
  logic                  ack_s;
  logic                  accept;

  // x_ack is only ever sampled by the first stage of this chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_DEPTH-2:0], x_ack};
  end

  assign ack_s    = ack_sync[SYNC_DEPTH-1];
  assign in_ready = (state == IDLE) & ~ack_s;
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      x_req  <= 1'b0;
      x_data <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            x_data <= in_data;
            x_req  <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            x_req <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: transfer-phase model checked every cycle, directed
// handshake scenarios and a randomized-latency receiver with an in-order scoreboard.
module tb_cdc_handshake_tx;
  localparam int WIDTH  = 32;
  localparam int SD     = 3;
  localparam int BUDGET = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             x_req;
  logic [WIDTH-1:0] x_data;
  logic             x_ack;
  logic             busy;
  logic             done;

  cdc_handshake_tx #(.WIDTH(WIDTH), .SYNC_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .x_req(x_req), .x_data(x_data), .x_ack(x_ack),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: transfer phase 0=idle, 1=waiting for ack, 2=waiting for ack release.
  // ack_q keeps the last SD sampled x_ack values; the oldest is what the block sees.
  int               m_phase;
  logic             m_req;
  logic [WIDTH-1:0] m_data;
  logic             m_done;
  bit               ack_q[$];

  function automatic bit model_ack_s();
    if (ack_q.size() < SD) return 1'b0;
    return ack_q[ack_q.size() - SD];
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit a;
    if (reset) begin
      m_phase <= 0;
      m_req   <= 1'b0;
      m_data  <= '0;
      m_done  <= 1'b0;
      ack_q.delete();
    end else begin
      a = model_ack_s();
      m_done <= 1'b0;
      if (m_phase == 0 && in_valid && !a) begin
        m_phase <= 1; m_req <= 1'b1; m_data <= in_data;
      end else if (m_phase == 1 && a) begin
        m_phase <= 2; m_req <= 1'b0;
      end else if (m_phase == 2 && !a) begin
        m_phase <= 0; m_done <= 1'b1;
      end
      ack_q.push_back(x_ack);
      if (ack_q.size() > SD) void'(ack_q.pop_front());
    end
  end

  logic             prev_req = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    if (!reset) begin
      check("x_req", x_req, m_req);
      check("x_data", x_data, m_data);
      check("busy", busy, m_phase != 0);
      check("done", done, m_done);
      check("in_ready", in_ready, (m_phase == 0) && !model_ack_s());
      if (x_req && prev_req) check("x_data_hold", x_data, prev_data);
      if (done) done_cnt++;
    end
    prev_req  <= x_req;
    prev_data <= x_data;
  end

  logic [WIDTH-1:0] sent[$];
  logic [WIDTH-1:0] rcvd[$];

  task automatic send(input logic [WIDTH-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else sent.push_back(w);
    @(negedge clk);
  endtask

  task automatic rx_one(input int lat_r, input int lat_f, output int fall_lat);
    int n = 0;
    while (!x_req && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!x_req) check("rx_req_timeout", 0, 1);
    rcvd.push_back(x_data);
    repeat (lat_r) @(negedge clk);
    x_ack = 1'b1;
    fall_lat = 0;
    while (x_req && fall_lat < BUDGET) begin
      @(negedge clk);
      fall_lat++;
    end
    repeat (lat_f) @(negedge clk);
    x_ack = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f, f2, d0, n;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; x_ack = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t1_x_req", x_req, 0);
    check("t1_x_data", x_data, 0);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_in_ready", in_ready, 1);
    @(negedge clk);
    check("t1_in_ready_cycle1", in_ready, 1);

    // single word, receiver answers 3 cycles after each edge of x_req
    d0 = done_cnt;
    fork
      begin send(32'hA5); in_valid = 1'b0; end
      rx_one(3, 3, f);
    join
    check("t2_fall_latency", f, SD + 1);
    wait_idle();
    check("t2_done_pulses", done_cnt - d0, 1);
    check("t2_in_ready", in_ready, 1);
    check("t2_rcvd", rcvd[rcvd.size()-1], 32'hA5);

    // producer holds valid across two words
    d0 = done_cnt;
    fork
      begin send(32'h11); send(32'h22); in_valid = 1'b0; end
      begin rx_one(2, 2, f); rx_one(1, 1, f2); end
    join
    wait_idle();
    check("t3_done_pulses", done_cnt - d0, 2);
    check("t3_word0", rcvd[rcvd.size()-2], 32'h11);
    check("t3_word1", rcvd[rcvd.size()-1], 32'h22);

    // stall with no ack while the producer wiggles its inputs
    d0 = done_cnt;
    send(32'h5A5A);
    rcvd.push_back(x_data);
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = WIDTH'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t4_x_req", x_req, 1);
    check("t4_busy", busy, 1);
    check("t4_x_data", x_data, 32'h5A5A);
    check("t4_no_done", done_cnt - d0, 0);
    x_ack = 1'b1;
    n = 0;
    while (x_req && n < BUDGET) begin @(negedge clk); n++; end
    x_ack = 1'b0;
    wait_idle();
    check("t4_done_after_ack", done_cnt - d0, 1);

    // reset in REQ while the ack is already up
    in_data = 32'h77; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < BUDGET) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    x_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("t5_in_req", x_req, 1);
    d0 = done_cnt;
    reset = 1'b1;
    #1;
    check("t5_x_req_async", x_req, 0);
    check("t5_busy_async", busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (SD + 2) @(negedge clk);
    check("t5_in_ready_stale_ack", in_ready, 0);
    x_ack = 1'b0;
    n = 0;
    while (!in_ready && n < BUDGET) begin @(negedge clk); n++; end
    check("t5_ready_delay", n, SD);
    check("t5_no_done", done_cnt - d0, 0);

    // randomized receiver latencies
    fork
      begin
        for (int i = 0; i < 500; i++) send(WIDTH'($urandom));
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 500; j++) rx_one($urandom_range(0, 20), $urandom_range(0, 20), f);
      end
    join
    wait_idle();
    check("t6_count", rcvd.size(), sent.size());
    for (int k = 0; k < sent.size() && k < rcvd.size(); k++)
      check("scoreboard_word", rcvd[k], sent[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
